// File: rtl/iob_bus_initiator_pkg.sv
// Shared types for the single-outstanding IOb initiator.
package iob_bus_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RSP    = 2'd3
  } state_t;

endpackage

// File: rtl/iob_bus_initiator_timer.sv
// Request/read-wait timeout counter for iob_bus_initiator.
// Only instantiated when IOB_BUS_INITIATOR_TIMEOUT_EN is defined.
module iob_bus_initiator_timer #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic cke_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt <= '0;
    end else if (cke_i) begin
      if (clr_i) begin
        cnt <= '0;
      end else if (en_i) begin
        cnt <= cnt + TIMEOUT_W'(1);
      end
    end
  end

  assign expired_o = en_i && (cnt == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/iob_bus_initiator.sv
// Single-outstanding IOb manager: one command in, one IOb transfer, one response out.
// Optional abort-on-timeout is enabled by defining IOB_BUS_INITIATOR_TIMEOUT_EN.
module iob_bus_initiator
  import iob_bus_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_we_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o
);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("iob_bus_initiator: DATA_W must be a multiple of 8");
  end
  if (TIMEOUT == 0 || 64'(TIMEOUT) >= (64'd1 << TIMEOUT_W)) begin : g_bad_timeout
    $error("iob_bus_initiator: TIMEOUT must be in 1 .. 2**TIMEOUT_W-1");
  end

  state_t state;
  logic   we_q;
  logic   err_q;
  logic   expired;

  assign cmd_ready_o = (state == IDLE);
  assign rsp_err_o   = err_q;

`ifdef IOB_BUS_INITIATOR_TIMEOUT_EN
  logic tmr_clr;
  logic tmr_en;

  // Restart on entry to either waiting state; REQ->WAIT_R restarts too.
  assign tmr_clr = ((state == IDLE) && cmd_valid_i) ||
                   ((state == REQ) && iob_ready_i && !we_q);
  assign tmr_en  = (state == REQ) || (state == WAIT_R);

  iob_bus_initiator_timer #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .cke_i     (cke_i),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      iob_valid_o <= 1'b0;
      iob_addr_o  <= '0;
      iob_wdata_o <= '0;
      iob_wstrb_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_we_o    <= 1'b0;
      rsp_rdata_o <= '0;
    end else if (cke_i) begin
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            state       <= REQ;
            we_q        <= cmd_we_i;
            err_q       <= 1'b0;
            iob_valid_o <= 1'b1;
            iob_addr_o  <= cmd_addr_i;
            iob_wdata_o <= cmd_wdata_i;
            iob_wstrb_o <= cmd_we_i ? cmd_wstrb_i : '0;
          end
        end
        REQ: begin
          // A handshake coinciding with the timeout limit takes priority.
          if (iob_ready_i) begin
            iob_valid_o <= 1'b0;
            if (we_q) begin
              state       <= RSP;
              rsp_valid_o <= 1'b1;
              rsp_we_o    <= 1'b1;
              rsp_rdata_o <= '0;
            end else begin
              state <= WAIT_R;
            end
          end else if (expired) begin
            state       <= RSP;
            iob_valid_o <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_we_o    <= we_q;
            rsp_rdata_o <= '0;
            err_q       <= 1'b1;
          end
        end
        WAIT_R: begin
          if (iob_rvalid_i) begin
            state       <= RSP;
            rsp_valid_o <= 1'b1;
            rsp_we_o    <= 1'b0;
            rsp_rdata_o <= iob_rdata_i;
          end else if (expired) begin
            state       <= RSP;
            rsp_valid_o <= 1'b1;
            rsp_we_o    <= we_q;
            rsp_rdata_o <= '0;
            err_q       <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
